// File: rtl/formula_res_credit_fifo.sv
// Credit-gated result FIFO between formula_1_pipe/formula_2_pipe and a consumer that can stall.
// Optional same-cycle bypass of an empty FIFO: define FORMULA_RES_FIFO_BYPASS_EN.
module formula_res_credit_fifo #(
  parameter int width = 32,
  parameter int depth = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_vld,
  output logic             up_rdy,
  output logic             arg_vld,
  input  logic             pipe_res_vld,
  input  logic [width-1:0] pipe_res,
  output logic             down_vld,
  input  logic             down_rdy,
  output logic [width-1:0] down_data,
  output logic             overflow
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  localparam logic [cw-1:0] full_c = cw'(depth);
  localparam logic [cw-1:0] zero_c = {cw{1'b0}};
  localparam logic [cw-1:0] one_c  = cw'(1);
  localparam logic [aw-1:0] step_c = aw'(1);

  logic [width-1:0] mem_r [depth];
  logic [aw-1:0]    wr_ptr_r;
  logic [aw-1:0]    rd_ptr_r;
  logic [cw-1:0]    count_r;
  logic [cw-1:0]    outstanding_r;
  logic             overflow_r;

  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             fifo_pop_s;
  logic             push_s;
  logic             bypass_s;
  logic             drop_s;
  logic [cw-1:0]    count_nxt_s;
  logic [cw-1:0]    outstanding_nxt_s;

  // Handshake decode and next-state arithmetic for occupancy and credits
  always_comb begin
    empty_s  = (count_r == zero_c);
    full_s   = (count_r == full_c);
    up_rdy   = (outstanding_r != full_c);
    arg_vld  = up_vld & up_rdy;
`ifdef FORMULA_RES_FIFO_BYPASS_EN
    down_vld = ~empty_s | pipe_res_vld;
    if (empty_s) begin
      down_data = pipe_res;
    end else begin
      down_data = mem_r[rd_ptr_r];
    end
    bypass_s = empty_s & pipe_res_vld & down_rdy;
`else
    down_vld  = ~empty_s;
    down_data = mem_r[rd_ptr_r];
    bypass_s  = 1'b0;
`endif
    pop_s      = down_vld & down_rdy;
    fifo_pop_s = pop_s & ~empty_s;
    // A full FIFO still accepts a result when its head leaves in the same cycle
    push_s     = pipe_res_vld & ~bypass_s & (~full_s | pop_s);
    drop_s     = pipe_res_vld & full_s & ~pop_s;

    case ({push_s, fifo_pop_s})
      2'b10:   count_nxt_s = count_r + one_c;
      2'b01:   count_nxt_s = count_r - one_c;
      default: count_nxt_s = count_r;
    endcase

    case ({arg_vld, pop_s})
      2'b10:   outstanding_nxt_s = outstanding_r + one_c;
      2'b01:   outstanding_nxt_s = outstanding_r - one_c;
      default: outstanding_nxt_s = outstanding_r;
    endcase
  end

  // Pointer, occupancy, credit and sticky error state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r      <= {aw{1'b0}};
      rd_ptr_r      <= {aw{1'b0}};
      count_r       <= zero_c;
      outstanding_r <= zero_c;
      overflow_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + step_c;
      end
      if (fifo_pop_s) begin
        rd_ptr_r <= rd_ptr_r + step_c;
      end
      count_r       <= count_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Result storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= pipe_res;
    end
  end

  assign overflow = overflow_r;

endmodule

// File: tb/tb_formula_res_credit_fifo.sv
// Self-checking bench for formula_res_credit_fifo: a stand-in pipe of fixed latency
// feeds the DUT while a queue-based model tracks expected results and credits.
module tb_formula_res_credit_fifo;

  localparam int W = 32;
  localparam int D = 16;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         up_vld = 1'b0;
  logic         up_rdy;
  logic         arg_vld;
  logic         pipe_res_vld = 1'b0;
  logic [W-1:0] pipe_res = '0;
  logic         down_vld;
  logic         down_rdy = 1'b0;
  logic [W-1:0] down_data;
  logic         overflow;

  always #5 clk = ~clk;

  formula_res_credit_fifo #(.width(W), .depth(D)) dut (
    .clk(clk), .rst(rst),
    .up_vld(up_vld), .up_rdy(up_rdy), .arg_vld(arg_vld),
    .pipe_res_vld(pipe_res_vld), .pipe_res(pipe_res),
    .down_vld(down_vld), .down_rdy(down_rdy), .down_data(down_data),
    .overflow(overflow)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: queue of results awaiting the consumer, credit count, sticky error
  logic [W-1:0] exp_q [$];
  int           m_out = 0;
  bit           m_ovf = 1'b0;
  bit           pv [L];
  logic [W-1:0] pd [L];
  logic [W-1:0] a = '0, b = '0, c = '0;
  bit           force_vld = 1'b0;
  logic [W-1:0] force_data = '0;

  function automatic logic [W-1:0] pipe_f(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W-1:0] z);
    return x * y + z;
  endfunction

  function bit m_up_rdy();
    return m_out != D;
  endfunction

  function bit m_down_vld();
`ifdef FORMULA_RES_FIFO_BYPASS_EN
    return (exp_q.size() != 0) || (pipe_res_vld == 1'b1);
`else
    return exp_q.size() != 0;
`endif
  endfunction

  function logic [W-1:0] m_down_data();
    if (exp_q.size() != 0) return exp_q[0];
    return pipe_res;
  endfunction

  task clear_model();
    exp_q.delete();
    m_out = 0;
    m_ovf = 1'b0;
    for (int i = 0; i < L; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
  endtask

  // Present the stand-in pipe output and let combinational outputs settle
  task pre();
    pipe_res_vld = force_vld ? 1'b1 : pv[L-1];
    pipe_res     = force_vld ? force_data : pd[L-1];
    #1;
  endtask

  // Clock edge: update model from the handshakes the inputs imply
  task post();
    bit fire, pop, byp;
    int sz;
    sz   = exp_q.size();
    fire = up_vld && m_up_rdy();
    pop  = m_down_vld() && down_rdy;
    byp  = 1'b0;
`ifdef FORMULA_RES_FIFO_BYPASS_EN
    byp  = (sz == 0) && pipe_res_vld && down_rdy;
`endif
    @(posedge clk);
    if (pop && sz != 0) void'(exp_q.pop_front());
    if (pipe_res_vld && !byp) begin
      if (sz != D || pop) exp_q.push_back(pipe_res);
      else m_ovf = 1'b1;
    end
    m_out = m_out + (fire ? 1 : 0) - (pop ? 1 : 0);
    for (int i = L - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = fire;
    pd[0] = pipe_f(a, b, c);
    cyc++;
    @(negedge clk);
  endtask

  task apply_reset();
    rst = 1'b1;
    up_vld = 1'b0;
    down_rdy = 1'b0;
    force_vld = 1'b0;
    pipe_res_vld = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task test_reset();
    clear_model();
    up_vld = 1'b1;
    #2 rst = 1'b1;
    #1;
    vectors++; if (down_vld !== 1'b0) begin miscompares++; $display("FAIL reset_down_vld got=%b exp=0", down_vld); end
    vectors++; if (up_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_up_rdy got=%b exp=1", up_rdy); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    vectors++; if (arg_vld !== 1'b1) begin miscompares++; $display("FAIL reset_arg_vld got=%b exp=1", arg_vld); end
    up_vld = 1'b0;
    @(negedge clk);
    apply_reset();
  endtask

  task test_single();
    int n_vld, pv_cyc, dv_cyc, exp_lat;
    n_vld = 0; pv_cyc = -100; dv_cyc = -1;
`ifdef FORMULA_RES_FIFO_BYPASS_EN
    exp_lat = 0;
`else
    exp_lat = 1;
`endif
    up_vld = 1'b1; down_rdy = 1'b1;
    a = 32'd1; b = 32'd4; c = 32'd9;
    pre();
    vectors++; if (arg_vld !== 1'b1) begin miscompares++; $display("FAIL t1_arg_vld got=%b exp=1", arg_vld); end
    post();
    up_vld = 1'b0;
    for (int i = 0; i < 12; i++) begin
      pre();
      if (pipe_res_vld) pv_cyc = i;
      if (down_vld === 1'b1) begin
        n_vld++;
        dv_cyc = i;
        vectors++; if (down_data !== 32'd13) begin miscompares++; $display("FAIL t1_data got=%0d exp=13", down_data); end
      end
      post();
    end
    vectors++; if (n_vld != 1) begin miscompares++; $display("FAIL t1_vld_count got=%0d exp=1", n_vld); end
    vectors++; if (dv_cyc - pv_cyc != exp_lat) begin miscompares++; $display("FAIL t1_latency got=%0d exp=%0d", dv_cyc - pv_cyc, exp_lat); end
    pre();
    vectors++; if (up_rdy !== 1'b1) begin miscompares++; $display("FAIL t1_up_rdy got=%b exp=1", up_rdy); end
  endtask

  task test_fill();
    int pulses;
    pulses = 0;
    up_vld = 1'b1; down_rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom; c = $urandom;
      pre();
      if (arg_vld === 1'b1) pulses++;
      vectors++; if (up_rdy !== m_up_rdy()) begin miscompares++; $display("FAIL t2_up_rdy cyc=%0d got=%b exp=%b", cyc, up_rdy, m_up_rdy()); end
      post();
    end
    pre();
    vectors++; if (pulses != D) begin miscompares++; $display("FAIL t2_pulses got=%0d exp=%0d", pulses, D); end
    vectors++; if (up_rdy !== 1'b0) begin miscompares++; $display("FAIL t2_up_rdy_end got=%b exp=0", up_rdy); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t2_overflow got=%b exp=0", overflow); end
    vectors++; if (down_vld !== 1'b1) begin miscompares++; $display("FAIL t2_down_vld got=%b exp=1", down_vld); end
  endtask

  task test_drain();
    down_rdy = 1'b1;
    for (int i = 0; i < 70; i++) begin
      up_vld = (i < 36) ? 1'b1 : 1'b0;
      a = $urandom; b = $urandom; c = $urandom;
      pre();
      if (i < D) begin
        vectors++; if (down_vld !== 1'b1) begin miscompares++; $display("FAIL t3_back_to_back i=%0d got=%b exp=1", i, down_vld); end
      end
      vectors++; if (down_vld !== m_down_vld()) begin miscompares++; $display("FAIL t3_down_vld cyc=%0d got=%b exp=%b", cyc, down_vld, m_down_vld()); end
      if (m_down_vld()) begin
        vectors++; if (down_data !== m_down_data()) begin miscompares++; $display("FAIL t3_data cyc=%0d got=%h exp=%h", cyc, down_data, m_down_data()); end
      end
      vectors++; if (arg_vld !== (up_vld && m_up_rdy())) begin miscompares++; $display("FAIL t3_arg_vld cyc=%0d got=%b", cyc, arg_vld); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t3_overflow cyc=%0d got=%b exp=0", cyc, overflow); end
      post();
    end
    pre();
    vectors++; if (down_vld !== 1'b0) begin miscompares++; $display("FAIL t3_empty got=%b exp=0", down_vld); end
  endtask

  task test_back_to_back();
    int lst [5] = '{0, 1, 4, 13, 40};
    int idx;
    logic [W-1:0] want;
    idx = 0;
    for (int i = 0; i < 30; i++) begin
      up_vld = (i < 5) ? 1'b1 : 1'b0;
      if (i < 5) begin
        a = W'(lst[i]); b = W'(lst[i]); c = W'(lst[i]);
      end
      down_rdy = (i % 2 == 0) ? 1'b1 : 1'b0;
      pre();
      vectors++; if (down_vld !== m_down_vld()) begin miscompares++; $display("FAIL t4_down_vld cyc=%0d got=%b exp=%b", cyc, down_vld, m_down_vld()); end
      if (down_vld === 1'b1 && down_rdy && idx < 5) begin
        want = pipe_f(W'(lst[idx]), W'(lst[idx]), W'(lst[idx]));
        vectors++; if (down_data !== want) begin miscompares++; $display("FAIL t4_order idx=%0d got=%0d exp=%0d", idx, down_data, want); end
        idx++;
      end
      post();
    end
    vectors++; if (idx != 5) begin miscompares++; $display("FAIL t4_pop_count got=%0d exp=5", idx); end
  endtask

  task test_overflow();
    up_vld = 1'b1; down_rdy = 1'b0;
    for (int i = 0; i < 28; i++) begin
      if (i == 24) up_vld = 1'b0;
      a = $urandom; b = $urandom; c = $urandom;
      pre();
      post();
    end
    force_vld = 1'b1; force_data = $urandom; down_rdy = 1'b1;
    pre();
    post();
    force_vld = 1'b0; down_rdy = 1'b0;
    pre();
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t5_push_with_pop got=%b exp=0", overflow); end
    vectors++; if (down_data !== m_down_data()) begin miscompares++; $display("FAIL t5_head got=%h exp=%h", down_data, m_down_data()); end
    post();
    force_vld = 1'b1; force_data = $urandom;
    pre();
    post();
    force_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pre();
      vectors++; if (overflow !== m_ovf) begin miscompares++; $display("FAIL t5_sticky i=%0d got=%b exp=%b", i, overflow, m_ovf); end
      post();
    end
    rst = 1'b1;
    #1;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t5_rst_clears got=%b exp=0", overflow); end
    apply_reset();
  endtask

  task test_reset_mid();
    down_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      up_vld = (i < 8 || i >= 14) ? 1'b1 : 1'b0;
      a = $urandom; b = $urandom; c = $urandom;
      pre();
      post();
    end
    pre();
    vectors++; if (down_vld !== 1'b1) begin miscompares++; $display("FAIL t6_held got=%b exp=1", down_vld); end
    rst = 1'b1;
    #1;
    vectors++; if (down_vld !== 1'b0) begin miscompares++; $display("FAIL t6_rst_down_vld got=%b exp=0", down_vld); end
    vectors++; if (up_rdy !== 1'b1) begin miscompares++; $display("FAIL t6_rst_up_rdy got=%b exp=1", up_rdy); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t6_rst_overflow got=%b exp=0", overflow); end
    apply_reset();
    for (int i = 0; i < 100; i++) begin
      up_vld   = (i < 70) ? 1'($urandom_range(0, 1)) : 1'b0;
      down_rdy = (i < 70) ? ($urandom_range(0, 3) != 0) : 1'b1;
      a = $urandom; b = $urandom; c = $urandom;
      pre();
      vectors++; if (down_vld !== m_down_vld()) begin miscompares++; $display("FAIL t6_down_vld cyc=%0d got=%b exp=%b", cyc, down_vld, m_down_vld()); end
      if (m_down_vld()) begin
        vectors++; if (down_data !== m_down_data()) begin miscompares++; $display("FAIL t6_data cyc=%0d got=%h exp=%h", cyc, down_data, m_down_data()); end
      end
      vectors++; if (up_rdy !== m_up_rdy()) begin miscompares++; $display("FAIL t6_up_rdy cyc=%0d got=%b exp=%b", cyc, up_rdy, m_up_rdy()); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t6_overflow cyc=%0d got=%b exp=0", cyc, overflow); end
      post();
    end
    pre();
    vectors++; if (down_vld !== 1'b0) begin miscompares++; $display("FAIL t6_final_empty got=%b exp=0", down_vld); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
